// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin select generator for a 4:1 mux with minimum dwell and lock.
// Drives registered {s1,s0}, a one-hot grant, sel_valid and a switch pulse.
module mux_sel_rr_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       lock,
    output logic       s0,
    output logic       s1,
    output logic [3:0] grant,
    output logic       sel_valid,
    output logic       switch_pulse
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             pulse_q, pulse_d;

    logic [2:0] pick_idle;
    logic [2:0] pick_next;

    // Returns {found, index}; lowest offset from start wins, so scan backwards.
    function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            cand = start + 2'(i);
            if (r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    assign pick_idle = rr_pick(req, ptr_q);
    assign pick_next = rr_pick(req, sel_q + 2'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        pulse_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_idle[2]) begin
                    state_d = S_GRANT;
                    sel_d   = pick_idle[1:0];
                    grant_d = 4'b0001 << pick_idle[1:0];
                    valid_d = 1'b1;
                    pulse_d = 1'b1;
                    cnt_d   = CNT_LOAD;
                    ptr_d   = pick_idle[1:0] + 2'd1;
                end
            end
            S_GRANT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (lock) begin
                    cnt_d = '0;
                end else if (pick_next[2]) begin
                    // The search wraps onto the current index last, so a
                    // same-index pick means it is the only requester left.
                    sel_d   = pick_next[1:0];
                    grant_d = 4'b0001 << pick_next[1:0];
                    pulse_d = (pick_next[1:0] != sel_q);
                    cnt_d   = CNT_LOAD;
                    ptr_d   = pick_next[1:0] + 2'd1;
                end else begin
                    state_d = S_IDLE;
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
        end
    end

    assign s0           = sel_q[0];
    assign s1           = sel_q[1];
    assign grant        = grant_q;
    assign sel_valid    = valid_q;
    assign switch_pulse = pulse_q;

endmodule
